// File: rtl/alu_result_serializer.sv
// Splits a registered ALU result into DATA_WIDTH-bit bytes, LSB first, and writes them
// into the TX FIFO under FIFO_FULL backpressure; a result arriving mid-transfer is dropped.
module alu_result_serializer #(
  parameter int RES_WIDTH  = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [RES_WIDTH-1:0]  ALU_OUT,
  input  logic                  ALU_VALID,
  input  logic                  FIFO_FULL,
  input  logic                  OVR_CLR,
  output logic [DATA_WIDTH-1:0] WR_DATA,
  output logic                  WR_INC,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  OVERRUN
);

  localparam int NUM_BYTES = RES_WIDTH / DATA_WIDTH;
  localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  if (RES_WIDTH % DATA_WIDTH != 0) begin : g_width_check
    $error("RES_WIDTH must be a multiple of DATA_WIDTH");
  end

  logic [0:0]           state_q, state_d;
  logic [RES_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 ovr_q, ovr_d;
  logic                 wr_inc;
  logic                 last_byte;

  assign wr_inc    = (state_q == SEND) && !FIFO_FULL;
  assign last_byte = wr_inc && (cnt_q == CNT_W'(NUM_BYTES - 1));

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q && !OVR_CLR;
    if (state_q == IDLE) begin
      if (ALU_VALID) begin
        shift_d = ALU_OUT;
        cnt_d   = '0;
        state_d = SEND;
      end
    end else begin
      if (wr_inc) begin
        shift_d = shift_q >> DATA_WIDTH;
        cnt_d   = cnt_q + CNT_W'(1);
      end
      if (last_byte) begin
        done_d = 1'b1;
        // A result arriving exactly on the last-byte edge chains on with no bubble.
        if (ALU_VALID) begin
          shift_d = ALU_OUT;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end else if (ALU_VALID) begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign WR_DATA = shift_q[DATA_WIDTH-1:0];
  assign WR_INC  = wr_inc;
  assign BUSY    = (state_q == SEND);
  assign DONE    = done_q;
  assign OVERRUN = ovr_q;

endmodule

// File: tb/tb_alu_result_serializer.sv
// Bench for alu_result_serializer: directed stimulus pushes expected FIFO bytes into a
// queue, and an independent monitor pops and compares every byte the DUT writes.
module tb_alu_result_serializer;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] ALU_OUT = '0;
  logic        ALU_VALID = 1'b0;
  logic        FIFO_FULL = 1'b0;
  logic        OVR_CLR = 1'b0;
  logic [7:0]  WR_DATA;
  logic        WR_INC;
  logic        BUSY;
  logic        DONE;
  logic        OVERRUN;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [7:0] exp_q[$];

  alu_result_serializer #(.RES_WIDTH(16), .DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .ALU_OUT(ALU_OUT), .ALU_VALID(ALU_VALID),
    .FIFO_FULL(FIFO_FULL), .OVR_CLR(OVR_CLR), .WR_DATA(WR_DATA),
    .WR_INC(WR_INC), .BUSY(BUSY), .DONE(DONE), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [15:0] val);
    ALU_OUT   = val;
    ALU_VALID = 1'b1;
    exp_q.push_back(val[7:0]);
    exp_q.push_back(val[15:8]);
  endtask

  // Monitor: every byte written to the FIFO must be the next one expected.
  always @(negedge CLK) begin
    if (RST && WR_INC) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got %h expected no write at %0t", WR_DATA, $time);
      end else begin
        chk("wr_data", 16'(WR_DATA), 16'(exp_q.pop_front()));
      end
    end
    if (RST && DONE) done_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    @(negedge CLK);
    chk("rst_wr_data", 16'(WR_DATA), 16'h0);
    chk("rst_wr_inc",  16'(WR_INC),  16'h0);
    chk("rst_busy",    16'(BUSY),    16'h0);
    chk("rst_done",    16'(DONE),    16'h0);
    chk("rst_overrun", 16'(OVERRUN), 16'h0);
    tick(); RST = 1'b1;
    tick();

    // Basic A55A transfer
    issue(16'hA55A);
    tick(); ALU_VALID = 1'b0;
    @(negedge CLK); chk("t1_busy0", 16'(BUSY), 16'h1); chk("t1_inc0", 16'(WR_INC), 16'h1);
    tick();
    @(negedge CLK); chk("t1_busy1", 16'(BUSY), 16'h1); chk("t1_inc1", 16'(WR_INC), 16'h1);
    chk("t1_done_early", 16'(DONE), 16'h0);
    tick();
    @(negedge CLK); chk("t1_busy2", 16'(BUSY), 16'h0); chk("t1_inc2", 16'(WR_INC), 16'h0);
    chk("t1_done", 16'(DONE), 16'h1);
    tick();
    @(negedge CLK); chk("t1_done_off", 16'(DONE), 16'h0);

    // 1234 with a 3-cycle stall after the first byte
    tick(); issue(16'h1234);
    tick(); ALU_VALID = 1'b0;
    tick(); FIFO_FULL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("t2_stall_inc",  16'(WR_INC),  16'h0);
      chk("t2_stall_data", 16'(WR_DATA), 16'h12);
      chk("t2_stall_busy", 16'(BUSY),    16'h1);
      tick();
    end
    FIFO_FULL = 1'b0;
    @(negedge CLK); chk("t2_resume_inc", 16'(WR_INC), 16'h1);
    tick();
    @(negedge CLK); chk("t2_done", 16'(DONE), 16'h1); chk("t2_busy", 16'(BUSY), 16'h0);

    // Back-to-back BEEF then CAFE on the last-byte cycle
    tick(); issue(16'hBEEF);
    tick(); ALU_VALID = 1'b0;
    tick(); issue(16'hCAFE);
    @(negedge CLK); chk("t3_inc1", 16'(WR_INC), 16'h1);
    tick(); ALU_VALID = 1'b0;
    @(negedge CLK); chk("t3_inc2", 16'(WR_INC), 16'h1); chk("t3_done1", 16'(DONE), 16'h1);
    chk("t3_busy", 16'(BUSY), 16'h1);
    tick();
    @(negedge CLK); chk("t3_inc3", 16'(WR_INC), 16'h1); chk("t3_done_gap", 16'(DONE), 16'h0);
    tick();
    @(negedge CLK); chk("t3_done2", 16'(DONE), 16'h1); chk("t3_inc_end", 16'(WR_INC), 16'h0);
    chk("t3_overrun", 16'(OVERRUN), 16'h0);

    // Overrun: 7777 arrives in the first SEND cycle and is dropped
    tick(); issue(16'h00FF);
    tick(); ALU_OUT = 16'h7777; ALU_VALID = 1'b1;
    @(negedge CLK); chk("t4_inc1", 16'(WR_INC), 16'h1);
    tick(); ALU_VALID = 1'b0;
    @(negedge CLK); chk("t4_ovr_set", 16'(OVERRUN), 16'h1);
    tick();
    @(negedge CLK); chk("t4_done", 16'(DONE), 16'h1); chk("t4_ovr_hold", 16'(OVERRUN), 16'h1);
    tick();
    @(negedge CLK); chk("t4_idle", 16'(BUSY), 16'h0); chk("t4_ovr_sticky", 16'(OVERRUN), 16'h1);

    // Drop coinciding with OVR_CLR: the set must win
    tick(); issue(16'h1111);
    tick(); ALU_OUT = 16'h2222; ALU_VALID = 1'b1; OVR_CLR = 1'b1;
    tick(); ALU_VALID = 1'b0; OVR_CLR = 1'b0;
    @(negedge CLK); chk("t4_set_wins", 16'(OVERRUN), 16'h1);
    tick();
    @(negedge CLK); chk("t4b_done", 16'(DONE), 16'h1);
    OVR_CLR = 1'b1;
    tick(); OVR_CLR = 1'b0;
    @(negedge CLK); chk("t4_ovr_clr", 16'(OVERRUN), 16'h0);

    // Reset mid-transfer after the first byte of AAAA
    tick(); ALU_OUT = 16'hAAAA; ALU_VALID = 1'b1; exp_q.push_back(8'hAA);
    tick(); ALU_VALID = 1'b0;
    tick(); RST = 1'b0;
    #1;
    chk("t5_rst_inc",  16'(WR_INC),  16'h0);
    chk("t5_rst_busy", 16'(BUSY),    16'h0);
    chk("t5_rst_data", 16'(WR_DATA), 16'h0);
    chk("t5_rst_done", 16'(DONE),    16'h0);
    tick(); tick(); RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("t5_no_inc", 16'(WR_INC), 16'h0);
      tick();
    end
    issue(16'h0102);
    tick(); ALU_VALID = 1'b0;
    tick(); tick();
    @(negedge CLK); chk("t5_done", 16'(DONE), 16'h1);

    // FIFO full while idle, then a result
    tick(); FIFO_FULL = 1'b1; issue(16'h3C4D);
    tick(); ALU_VALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("t6_busy",  16'(BUSY),    16'h1);
      chk("t6_inc",   16'(WR_INC),  16'h0);
      chk("t6_data",  16'(WR_DATA), 16'h4D);
      tick();
    end
    FIFO_FULL = 1'b0;
    @(negedge CLK); chk("t6_inc1", 16'(WR_INC), 16'h1);
    tick();
    @(negedge CLK); chk("t6_inc2", 16'(WR_INC), 16'h1);
    tick();
    @(negedge CLK); chk("t6_done", 16'(DONE), 16'h1);

    tick(); tick();
    chk("queue_empty", 16'(exp_q.size()), 16'h0);
    chk("done_count",  16'(done_cnt),     16'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_result_serializer.md
Name: alu_result_serializer

Overview:
- Sits directly downstream of the ALU output register stage.
- Captures a registered ALU result of RES_WIDTH bits on its one-cycle valid strobe and splits it into DATA_WIDTH-bit bytes, least-significant byte first.
- Pushes the bytes into the TX async FIFO write port and respects the FIFO full flag.
- Frees the system controller from byte-splitting and backpressure handling.

Parameters:
- RES_WIDTH, 16, width of the ALU result word; must be an integer multiple of DATA_WIDTH.
- DATA_WIDTH, 8, width of the FIFO write data (one UART frame).
- NUM_BYTES, RES_WIDTH/DATA_WIDTH, number of bytes per result; derived, not overridden.

Ports:
- CLK  in  1  reference clock; single clock domain; all state updates on its rising edge.
- RST  in  1  asynchronous, active-low reset; clears all state immediately.
- ALU_OUT  in  RES_WIDTH  registered ALU result.
- ALU_VALID  in  1  one-cycle strobe; ALU_OUT is valid in this cycle.
- FIFO_FULL  in  1  TX FIFO full flag, already synchronised into CLK.
- WR_DATA  out  DATA_WIDTH  byte presented to the FIFO.
- WR_INC  out  1  FIFO write enable; FIFO samples WR_DATA at the edge ending a cycle with WR_INC=1.
- BUSY  out  1  high while a result is being serialised.
- DONE  out  1  one-cycle pulse after the last byte of a result is written.
- OVERRUN  out  1  sticky flag: a result was dropped.
- OVR_CLR  in  1  synchronous clear of OVERRUN.

Behaviour:
- Reset values: state=IDLE, shift register=0, byte counter=0, WR_DATA=0, WR_INC=0, BUSY=0, DONE=0, OVERRUN=0.
- Reset asserted mid-transfer aborts the transfer. No further WR_INC occurs and the partial result is discarded.
- State machine has two states, IDLE and SEND.
- IDLE:
  - ALU_VALID=1 captures ALU_OUT into the shift register, clears the byte counter and moves to SEND at the next edge.
  - ALU_VALID=0 holds IDLE.
- SEND:
  - BUSY=1.
  - WR_DATA is the low DATA_WIDTH bits of the shift register, driven directly from a register.
  - WR_INC = (state==SEND) & ~FIFO_FULL. This is the only combinational output.
- Each edge with WR_INC=1:
  - Shift register shifts right by DATA_WIDTH, zero-filled.
  - Byte counter increments.
- Last-byte edge (WR_INC=1 and counter==NUM_BYTES-1):
  - DONE pulses high for the next cycle.
  - If ALU_VALID=1 in that same cycle, the new result is captured, the counter clears and the block stays in SEND with no bubble.
  - Otherwise the block returns to IDLE.
- FIFO_FULL=1 in SEND: WR_INC=0; shift register and counter hold; WR_DATA is stable.
- ALU_VALID=1 in SEND other than on the last-byte edge: the result is dropped, OVERRUN is set, and the transfer in progress is unaffected.
- OVR_CLR=1: OVERRUN clears next edge. If a drop happens in the same cycle, the set wins.
- Latency:
  - ALU_VALID sampled at edge k gives first WR_INC in cycle k+1 when FIFO_FULL=0.
  - With FIFO_FULL=0, WR_INC is high for exactly NUM_BYTES consecutive cycles.
  - DONE is high in cycle k+1+NUM_BYTES.
- ALU_VALID is ignored as a level; only the cycles where it is high are sampled.

Test Plan:
- Reset, then ALU_OUT=16'hA55A with ALU_VALID for one cycle, FIFO_FULL=0 -> WR_INC high 2 consecutive cycles with WR_DATA 8'h5A then 8'hA5; DONE pulses the following cycle; BUSY high exactly 2 cycles.
- Result 16'h1234; FIFO_FULL=1 for 3 cycles after the first byte is written -> bytes 8'h34 and 8'h12 written once each; no WR_INC while full; WR_DATA holds 8'h12 throughout the stall.
- Back-to-back: 16'hBEEF, then 16'hCAFE with ALU_VALID on the last-byte cycle -> FIFO receives EF, BE, FE, CA with no idle cycle; OVERRUN=0; two DONE pulses.
- Overrun: 16'h00FF, then ALU_VALID with 16'h7777 in the first SEND cycle -> FIFO receives only FF, 00; OVERRUN=1 and stays set; OVR_CLR pulse -> OVERRUN=0 next cycle.
- Reset mid-operation: RST low after the first byte of 16'hAAAA -> outputs zero immediately; after release there is no WR_INC until a new ALU_VALID; a following 16'h0102 produces 02, 01.
- FIFO_FULL held high with the block idle, then ALU_VALID -> BUSY=1 and WR_INC=0 until full drops, then normal 2-byte transfer.
